fp32_reduce_ctrl: RTL and testbench

- Streaming max/min reduction controller for FP32 vectors.
- Accepts a start command with a vector length, then consumes one FP32 element per cycle over a valid/ready stream.
- Tracks the running max (or min) value and its element index, and reports the result, index and a NaN flag at end of vector.
- Sits after the INTtoFP32 and FP32 compare datapath; it sequences compare/select over a whole vector instead of a single pair.

---
 rtl/fp32_reduce_ctrl.sv | 158 +++++++++++++++
 tb/tb_fp32_reduce_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_reduce_ctrl.sv
// Streaming FP32 max/min reduction over a vector of 1..2**IDX_W elements, reporting value, index and NaN flag.
// Latency: the result pulse comes one cycle after the last element handshake; a zero length finishes one cycle after start.
// Backpressure: o_ready is high only in RUN; elements offered in IDLE or DONE are not consumed, and i_start outside IDLE is ignored.
module fp32_reduce_ctrl #(
   parameter int          IDX_W = 10,
   parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   input  logic [IDX_W:0]   i_len,
   input  logic             i_is_max,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_data,
   output logic             o_busy,
   output logic             o_res_valid,
   output logic [31:0]      o_res,
   output logic [IDX_W-1:0] o_res_idx,
   output logic             o_nan_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t           state;
   logic [IDX_W:0]   vec_len;
   logic [IDX_W:0]   count;
   logic             is_max;
   logic             have_best;
   logic             nan_seen;
   logic [31:0]      best_dat;
   logic [31:0]      best_key;
   logic [IDX_W-1:0] best_idx;

   logic             elem_nan;
   logic [31:0]      norm;
   logic [31:0]      key;
   logic             better;
   logic             take;
   logic             fin_have;
   logic [31:0]      fin_dat;
   logic [IDX_W-1:0] fin_idx;
   logic             fin_nan;
   logic             last;
   logic             hs;

   // Order the incoming element against the running best and form the post-update values.
   always_comb begin
      elem_nan = 1'b0;
      norm     = 32'd0;
      key      = 32'd0;
      better   = 1'b0;
      take     = 1'b0;
      elem_nan = (i_data[30:23] == 8'hFF) && (i_data[22:0] != 23'd0);
      // -0 and +0 must share one key so ties between them keep the earliest index.
      norm     = (i_data[30:0] == 31'd0) ? 32'd0 : i_data;
      key      = norm[31] ? ~norm : (norm ^ 32'h8000_0000);
      if (!have_best) begin
         better = 1'b1;
      end else if (is_max) begin
         better = (key > best_key);
      end else begin
         better = (key < best_key);
      end
      take     = !elem_nan && better;
      fin_have = have_best || take;
      fin_dat  = take ? i_data : best_dat;
      fin_idx  = take ? count[IDX_W-1:0] : best_idx;
      fin_nan  = nan_seen || elem_nan;
      hs       = i_valid && o_ready;
      last     = (count == (vec_len - ONE));
   end

   // Control FSM with registered handshake, status and result outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         vec_len     <= '0;
         count       <= '0;
         is_max      <= 1'b0;
         have_best   <= 1'b0;
         nan_seen    <= 1'b0;
         best_dat    <= 32'd0;
         best_key    <= 32'd0;
         best_idx    <= '0;
         o_ready     <= 1'b0;
         o_busy      <= 1'b0;
         o_res_valid <= 1'b0;
         o_res       <= 32'd0;
         o_res_idx   <= '0;
         o_nan_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_res_valid <= 1'b0;
               if (i_start) begin
                  o_busy <= 1'b1;
                  if (i_len != '0) begin
                     vec_len   <= i_len;
                     is_max    <= i_is_max;
                     count     <= '0;
                     have_best <= 1'b0;
                     nan_seen  <= 1'b0;
                     o_ready   <= 1'b1;
                     state     <= RUN;
                  end else begin
                     o_res       <= QNAN;
                     o_res_idx   <= '0;
                     o_nan_err   <= 1'b0;
                     o_res_valid <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            RUN: begin
               if (hs) begin
                  count     <= count + ONE;
                  nan_seen  <= fin_nan;
                  have_best <= fin_have;
                  if (take) begin
                     best_dat <= i_data;
                     best_key <= key;
                     best_idx <= count[IDX_W-1:0];
                  end
                  if (last) begin
                     // An all-NaN vector never sets have_best and reports the canonical NaN.
                     o_res       <= fin_have ? fin_dat : QNAN;
                     o_res_idx   <= fin_have ? fin_idx : '0;
                     o_nan_err   <= fin_nan;
                     o_res_valid <= 1'b1;
                     o_ready     <= 1'b0;
                     state       <= DONE;
                  end
               end
            end
            DONE: begin
               o_res_valid <= 1'b0;
               o_busy      <= 1'b0;
               o_ready     <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               o_res_valid <= 1'b0;
               o_busy      <= 1'b0;
               o_ready     <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_reduce_ctrl.sv
// Directed bench for fp32_reduce_ctrl: a driver issues vectors and queues the expected results,
// a negedge monitor pops and compares on each result pulse, including the cycle it arrives in.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fp32_reduce_ctrl;

   localparam int          IDX_W = 10;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef struct {
      logic [31:0] res;
      int          idx;
      logic        nan;
      int          edge_no;
   } exp_t;

   logic             clk;
   logic             rstn;
   logic             i_start;
   logic [IDX_W:0]   i_len;
   logic             i_is_max;
   logic             i_valid;
   logic             o_ready;
   logic [31:0]      i_data;
   logic             o_busy;
   logic             o_res_valid;
   logic [31:0]      o_res;
   logic [IDX_W-1:0] o_res_idx;
   logic             o_nan_err;

   int   checks = 0;
   int   errors = 0;
   int   edges  = 0;
   exp_t sb[$];
   logic prev_vld = 1'b0;

   fp32_reduce_ctrl #(.IDX_W(IDX_W), .QNAN(QNAN)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_start    (i_start),
      .i_len      (i_len),
      .i_is_max   (i_is_max),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
      .o_busy     (o_busy),
      .o_res_valid(o_res_valid),
      .o_res      (o_res),
      .o_res_idx  (o_res_idx),
      .o_nan_err  (o_nan_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edges++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every result pulse is matched against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (o_res_valid === 1'b1) begin
         chk("pulse_width", {31'd0, prev_vld}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("res", o_res, e.res);
            chk("res_idx", {22'd0, o_res_idx}, e.idx);
            chk("nan_err", {31'd0, o_nan_err}, {31'd0, e.nan});
            chk("pulse_cycle", edges, e.edge_no);
         end
      end
      prev_vld = o_res_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse i_start for one edge; returns the edge that sampled it.
   task automatic do_start(input int len, input logic mx, output int st_edge);
      i_start  = 1'b1;
      i_len    = len[IDX_W:0];
      i_is_max = mx;
      tick();
      i_start  = 1'b0;
      st_edge  = edges;
   endtask

   // Offer one element, optionally after a stall; an i_start pulse may be injected during the stall.
   task automatic send(input logic [31:0] d, input int stall, input logic inject_start, output int hs_edge);
      logic hs;
      int   n;
      i_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
         i_start = inject_start && (s == 0);
         i_len   = 11'd1;
         i_is_max = 1'b0;
         i_data  = 32'hDEAD_BEEF;
         tick();
         i_start = 1'b0;
      end
      i_valid = 1'b1;
      i_data  = d;
      hs      = 1'b0;
      n       = 0;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = o_ready;
         tick();
         n++;
      end
      if (!hs) chk("handshake_timeout", 32'd1, 32'd0);
      hs_edge = edges;
      i_valid = 1'b0;
   endtask

   task automatic run_vec(input int len, input logic mx,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [31:0] er, input int ei, input logic en,
                          input int stall_pos);
      logic [31:0] dv[4];
      int          st;
      int          he;
      exp_t        e;
      dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
      do_start(len, mx, st);
      he = st;
      if (len != 0) chk("busy_run", {31'd0, o_busy}, 32'd1);
      for (int k = 0; k < len; k++) begin
         send(dv[k], (k == stall_pos) ? 5 : 0, k == stall_pos, he);
      end
      e.res = er; e.idx = ei; e.nan = en; e.edge_no = he;
      sb.push_back(e);
      tick();
      tick();
   endtask

   initial begin
      int st;
      int he;
      rstn     = 1'b0;
      i_start  = 1'b0;
      i_len    = '0;
      i_is_max = 1'b0;
      i_valid  = 1'b0;
      i_data   = 32'd0;
      repeat (3) tick();
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_res", o_res, 32'd0);
      chk("rst_valid", {31'd0, o_res_valid}, 32'd0);
      rstn = 1'b1;
      tick();

      // Element offered while idle must not be consumed and must not start anything.
      i_valid = 1'b1;
      i_data  = 32'h4000_0000;
      tick();
      chk("idle_ready", {31'd0, o_ready}, 32'd0);
      i_valid = 1'b0;

      run_vec(4, 1'b1, 32'h3F80_0000, 32'hC1D8_0000, 32'h40B0_0000, 32'h4000_0000,
              32'h40B0_0000, 2, 1'b0, -1);
      repeat (3) tick();
      chk("res_held", o_res, 32'h40B0_0000);
      chk("idle_busy", {31'd0, o_busy}, 32'd0);

      run_vec(3, 1'b0, 32'hC1D8_0000, 32'hC1D8_0000, 32'h0000_0000, 32'd0,
              32'hC1D8_0000, 0, 1'b0, -1);
      run_vec(3, 1'b1, 32'h8000_0000, 32'h7FC0_0001, 32'h0000_0000, 32'd0,
              32'h8000_0000, 0, 1'b1, -1);
      run_vec(0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, QNAN, 0, 1'b0, -1);
      run_vec(2, 1'b1, 32'h7FC0_0001, 32'hFFC0_0000, 32'd0, 32'd0, QNAN, 0, 1'b1, -1);
      run_vec(3, 1'b1, 32'h3F80_0000, 32'h40B0_0000, 32'h4000_0000, 32'd0,
              32'h40B0_0000, 1, 1'b0, 1);
      run_vec(2, 1'b0, 32'hFF80_0000, 32'h7F80_0000, 32'd0, 32'd0,
              32'hFF80_0000, 0, 1'b0, -1);
      run_vec(3, 1'b0, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 32'd0,
              32'hC000_0000, 1, 1'b0, -1);

      // Abort mid-vector: two of four elements accepted, then reset.
      do_start(4, 1'b1, st);
      send(32'h4100_0000, 0, 1'b0, he);
      send(32'h4200_0000, 0, 1'b0, he);
      rstn = 1'b0;
      #1;
      chk("abort_res", o_res, 32'd0);
      chk("abort_idx", {22'd0, o_res_idx}, 32'd0);
      chk("abort_nan", {31'd0, o_nan_err}, 32'd0);
      chk("abort_busy", {31'd0, o_busy}, 32'd0);
      chk("abort_ready", {31'd0, o_ready}, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      tick();
      run_vec(3, 1'b1, 32'h3F80_0000, 32'h40B0_0000, 32'h4000_0000, 32'd0,
              32'h40B0_0000, 1, 1'b0, -1);

      repeat (4) tick();
      chk("all_results_seen", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
